bcd_seg_scan: RTL and testbench

//   Multiplexed 3-digit 7-segment display driver. Sits directly downstream of the
//   8-bit binary-to-BCD converter and consumes its bcd_unit/bcd_ten/bcd_hundred.

---
 rtl/bcd_seg_scan.sv | 214 +++++++++++++++++++++
 tb/tb_bcd_seg_scan.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
//   Multiplexed 3-digit 7-segment display driver fed by a binary-to-BCD
//   converter. Digits are captured on a load strobe into a shadow set and
//   applied to the display set only at frame boundaries, so one frame never
//   mixes old and new digits. Each digit slot starts with a short all-dark
//   interval (anti-ghosting). Leading zeros are suppressed.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst          in   1  asynchronous reset, active-high
//   load         in   1  capture bcd_* this cycle
//   bcd_unit     in   4  units digit
//   bcd_ten      in   4  tens digit
//   bcd_hundred  in   4  hundreds digit
//   seg          out  7  segments {g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW=1
//   an           out  3  one-hot active-high digit enable: [0]=unit [1]=ten [2]=hundred
//   frame_done   out  1  1-cycle pulse after each frame boundary
//   bad_digit    out  1  last loaded set contained a digit > 9
module bcd_seg_scan #(
    parameter int DIV_COUNT      = 50000,
    parameter int DIV_WIDTH      = 16,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] bcd_unit,
    input  logic [3:0] bcd_ten,
    input  logic [3:0] bcd_hundred,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done,
    output logic       bad_digit
);

    typedef enum logic [1:0] {
        S_UNIT = 2'd0,
        S_TEN  = 2'd1,
        S_HUND = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_LAST   = DIV_WIDTH'(DIV_COUNT - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_INIT = DIV_WIDTH'(BLANK_CYCLES);
    localparam logic [6:0]           SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    // Active-high gfedcba pattern; anything above 9 shows a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] blank_q, blank_d;
    state_t               state_q, state_d;
    logic [3:0]           shd_u_q, shd_t_q, shd_h_q;
    logic [3:0]           shd_u_d, shd_t_d, shd_h_d;
    logic [3:0]           disp_u_q, disp_t_q, disp_h_q;
    logic [3:0]           disp_u_d, disp_t_d, disp_h_d;
    logic                 pend_q, pend_d;
    logic [2:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 frame_done_q, frame_done_d;
    logic                 bad_digit_q, bad_digit_d;

    logic       tick;
    logic       boundary;
    logic [3:0] cur_digit;
    logic [2:0] cur_an;
    logic       dark;
    logic [6:0] seg_hi;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cnt_d        = cnt_q + 1'b1;
        blank_d      = blank_q;
        state_d      = state_q;
        shd_u_d      = shd_u_q;
        shd_t_d      = shd_t_q;
        shd_h_d      = shd_h_q;
        disp_u_d     = disp_u_q;
        disp_t_d     = disp_t_q;
        disp_h_d     = disp_h_q;
        pend_d       = pend_q;
        bad_digit_d  = bad_digit_q;
        cur_digit    = disp_u_q;
        cur_an       = 3'b001;
        dark         = 1'b0;
        seg_hi       = 7'h00;
        an_d         = 3'b000;

        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (state_q == S_HUND);

        // Prescaler and scan sequencing.
        if (tick) begin
            cnt_d = '0;
            case (state_q)
                S_UNIT:  state_d = S_TEN;
                S_TEN:   state_d = S_HUND;
                default: state_d = S_UNIT;
            endcase
        end

        // Each new slot opens with a dark interval.
        if (tick) begin
            blank_d = BLANK_INIT;
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end

        // Load capture; a load landing on the boundary bypasses the shadow so
        // it shows in the very next frame.
        if (load) begin
            shd_u_d     = bcd_unit;
            shd_t_d     = bcd_ten;
            shd_h_d     = bcd_hundred;
            bad_digit_d = (bcd_unit > 4'd9) || (bcd_ten > 4'd9) || (bcd_hundred > 4'd9);
        end
        if (boundary && load) begin
            disp_u_d = bcd_unit;
            disp_t_d = bcd_ten;
            disp_h_d = bcd_hundred;
            pend_d   = 1'b0;
        end else if (boundary && pend_q) begin
            disp_u_d = shd_u_q;
            disp_t_d = shd_t_q;
            disp_h_d = shd_h_q;
            pend_d   = 1'b0;
        end else if (load) begin
            pend_d   = 1'b1;
        end

        // Leading-zero suppression: only a true 0 is suppressed, never a dash.
        case (state_q)
            S_TEN: begin
                cur_digit = disp_t_q;
                cur_an    = 3'b010;
                dark      = (disp_h_q == 4'd0) && (disp_t_q == 4'd0);
            end
            S_HUND: begin
                cur_digit = disp_h_q;
                cur_an    = 3'b100;
                dark      = (disp_h_q == 4'd0);
            end
            default: begin
                cur_digit = disp_u_q;
                cur_an    = 3'b001;
                dark      = 1'b0;
            end
        endcase

        if (!dark && (blank_q == '0)) begin
            an_d   = cur_an;
            seg_hi = decode(cur_digit);
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;

        frame_done_d = boundary;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            blank_q      <= '0;
            state_q      <= S_UNIT;
            shd_u_q      <= '0;
            shd_t_q      <= '0;
            shd_h_q      <= '0;
            disp_u_q     <= '0;
            disp_t_q     <= '0;
            disp_h_q     <= '0;
            pend_q       <= 1'b0;
            an_q         <= 3'b000;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
            bad_digit_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            blank_q      <= blank_d;
            state_q      <= state_d;
            shd_u_q      <= shd_u_d;
            shd_t_q      <= shd_t_d;
            shd_h_q      <= shd_h_d;
            disp_u_q     <= disp_u_d;
            disp_t_q     <= disp_t_d;
            disp_h_q     <= disp_h_d;
            pend_q       <= pend_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            bad_digit_q  <= bad_digit_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign bad_digit  = bad_digit_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan
//   Directed bench for bcd_seg_scan with DIV_COUNT=4, BLANK_CYCLES=1,
//   SEG_ACTIVE_LOW=0. A frame is 12 cycles. Taking F as the edge that
//   raises frame_done, outputs sampled on the falling edge show: F+1 blank,
//   F+2..F+4 unit, F+5 blank, F+6..F+8 ten, F+9 blank, F+10..F+12 hundred,
//   with frame_done again after F+12.
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] bcd_unit;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_hundred;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;
    logic       bad_digit;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_seg_scan #(
        .DIV_COUNT      (4),
        .DIV_WIDTH      (16),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bcd_unit    (bcd_unit),
        .bcd_ten     (bcd_ten),
        .bcd_hundred (bcd_hundred),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done),
        .bad_digit   (bad_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_load(input logic [3:0] u, input logic [3:0] t, input logic [3:0] h);
        load        = 1'b1;
        bcd_unit    = u;
        bcd_ten     = t;
        bcd_hundred = h;
    endtask

    // Step until frame_done is seen, bounded; returns cycles taken.
    task automatic wait_frame(output int cycles);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            cycles++;
            if (frame_done === 1'b1) break;
        end
        check("frame_done_seen", {7'd0, frame_done}, 8'h01);
    endtask

    // Called right after a boundary; checks one whole frame and ends at the next boundary.
    task automatic check_frame(input string name,
                               input logic [2:0] an_u, input logic [6:0] seg_u,
                               input logic [2:0] an_t, input logic [6:0] seg_t,
                               input logic [2:0] an_h, input logic [6:0] seg_h);
        step(1);
        check({name, "_blank_an"},  {5'd0, an},  8'h00);
        check({name, "_blank_seg"}, {1'b0, seg}, 8'h00);
        check({name, "_fd_pulse"},  {7'd0, frame_done}, 8'h00);
        step(1);
        check({name, "_unit_an"},  {5'd0, an},  {5'd0, an_u});
        check({name, "_unit_seg"}, {1'b0, seg}, {1'b0, seg_u});
        step(4);
        check({name, "_ten_an"},  {5'd0, an},  {5'd0, an_t});
        check({name, "_ten_seg"}, {1'b0, seg}, {1'b0, seg_t});
        step(4);
        check({name, "_hund_an"},  {5'd0, an},  {5'd0, an_h});
        check({name, "_hund_seg"}, {1'b0, seg}, {1'b0, seg_h});
        step(2);
        check({name, "_fd"}, {7'd0, frame_done}, 8'h01);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        load        = 1'b0;
        bcd_unit    = 4'd0;
        bcd_ten     = 4'd0;
        bcd_hundred = 4'd0;

        // Reset state.
        step(3);
        check("rst_an",  {5'd0, an},  8'h00);
        check("rst_seg", {1'b0, seg}, 8'h00);
        check("rst_fd",  {7'd0, frame_done}, 8'h00);
        check("rst_bad", {7'd0, bad_digit},  8'h00);
        rst = 1'b0;

        // First edge after release: unit slot shows "0".
        step(1);
        check("post_rst_an",  {5'd0, an},  8'h01);
        check("post_rst_seg", {1'b0, seg}, 8'h3F);
        wait_frame(cyc);
        check("first_frame_len", 8'(cyc), 8'd11);
        check_frame("zero", 3'b001, 7'h3F, 3'b000, 7'h00, 3'b000, 7'h00);

        // Mid-frame load of 1/5/2: old digits persist until the boundary.
        step(1);
        step(1);
        check("midload_old_unit", {1'b0, seg}, 8'h3F);
        drive_load(4'd2, 4'd5, 4'd1);
        step(1);
        load = 1'b0;
        step(3);
        check("midload_old_ten",  {5'd0, an}, 8'h00);
        step(4);
        check("midload_old_hund", {5'd0, an}, 8'h00);
        step(2);
        check("midload_fd", {7'd0, frame_done}, 8'h01);
        check_frame("n152", 3'b001, 7'h5B, 3'b010, 7'h6D, 3'b100, 7'h06);

        // Two loads before one boundary: the last one wins.
        step(1);
        drive_load(4'd0, 4'd7, 4'd0);
        step(1);
        drive_load(4'd3, 4'd0, 4'd0);
        step(1);
        load = 1'b0;
        step(9);
        check("lastwin_fd", {7'd0, frame_done}, 8'h01);
        check_frame("n3", 3'b001, 7'h4F, 3'b000, 7'h00, 3'b000, 7'h00);

        // Load coincident with the boundary edge: shows in the very next frame.
        step(11);
        drive_load(4'd0, 4'd0, 4'd1);
        step(1);
        load = 1'b0;
        check("coinc_fd", {7'd0, frame_done}, 8'h01);
        check_frame("n100", 3'b001, 7'h3F, 3'b010, 7'h3F, 3'b100, 7'h06);
        check_frame("n100_hold", 3'b001, 7'h3F, 3'b010, 7'h3F, 3'b100, 7'h06);

        // Invalid unit digit: bad_digit next cycle, unit shows a dash.
        step(1);
        drive_load(4'hC, 4'd0, 4'd0);
        step(1);
        load = 1'b0;
        check("bad_set", {7'd0, bad_digit}, 8'h01);
        step(10);
        check("bad_fd", {7'd0, frame_done}, 8'h01);
        check_frame("dash", 3'b001, 7'h40, 3'b000, 7'h00, 3'b000, 7'h00);

        // Valid load clears bad_digit; "800" keeps inner zeros.
        step(1);
        drive_load(4'd0, 4'd0, 4'd8);
        step(1);
        load = 1'b0;
        check("bad_clr", {7'd0, bad_digit}, 8'h00);
        step(10);
        check("n800_fd", {7'd0, frame_done}, 8'h01);
        check_frame("n800", 3'b001, 7'h3F, 3'b010, 7'h3F, 3'b100, 7'h7F);

        // Reset mid-slot with a pending load.
        step(6);
        check("prerst_an",  {5'd0, an},  8'h02);
        check("prerst_seg", {1'b0, seg}, 8'h3F);
        drive_load(4'd3, 4'd2, 4'd1);
        step(1);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_an",  {5'd0, an},  8'h00);
        check("midrst_seg", {1'b0, seg}, 8'h00);
        check("midrst_fd",  {7'd0, frame_done}, 8'h00);
        check("midrst_bad", {7'd0, bad_digit},  8'h00);
        step(2);
        rst = 1'b0;
        step(1);
        check("rel_an",  {5'd0, an},  8'h01);
        check("rel_seg", {1'b0, seg}, 8'h3F);
        wait_frame(cyc);
        check("rel_frame_len", 8'(cyc), 8'd11);
        check_frame("discard", 3'b001, 7'h3F, 3'b000, 7'h00, 3'b000, 7'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
